bitserial_layer_sched: RTL
==========================

// Module: bitserial_layer_sched
// PURPOSE
//  Sequencer for one bitserial_nn fully-connected layer: walks output neurons in groups of P lanes.
//  Per group: issues weight/input-bit reads, drives the P bit-serial MAC lanes, then streams P results out.
//  Sits between the input buffer / weight memory and the output FIFO; holds no data, only control.
// PARAMETERS
//  N_IN      128  inputs per neuron (>=2)
//  N_HIDDEN  64   output neurons (>=1)
//  P         4    parallel MAC lanes (>=1)
//  PRECISION 16   input bit planes, LSB first; MSB plane is the two's-complement sign plane
//  MEM_LAT   1    weight/input read latency in cycles (>=1)
// PORTS
//  clk        in  1                 clock
//  rst        in  1                 async reset, active-high
//  start      in  1                 run request; sampled only in IDLE
//  abort      in  1                 sync abort; back to IDLE next cycle, no done
//  in_ready   in  1                 input buffer holds a full vector
//  busy       out 1                 high in every state except IDLE
//  done       out 1                 1-cycle pulse after last result accepted
//  rd_en      out 1                 read strobe to weight mem and input buffer
//  rd_addr_h  out clog2(N_HIDDEN)   group base neuron (g*P)
//  rd_addr_i  out clog2(N_IN)       input index
//  rd_bit     out clog2(PRECISION)  input bit plane
//  mac_clr    out 1                 clear all lane accumulators
//  mac_en     out 1                 accumulate (rd_en delayed MEM_LAT)
//  mac_bit    out clog2(PRECISION)  rd_bit delayed MEM_LAT; sets weight shift
//  mac_sign   out 1                 delayed (rd_bit==PRECISION-1); lane subtracts
//  out_valid  out 1                 a lane result is presented
//  out_ready  in  1                 downstream accepts
//  out_lane   out clog2(P)          lane selected onto the result mux
//  out_neuron out clog2(N_HIDDEN)   global neuron index of presented result
//  perf_cycles out 32               run cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; delay line, counters cleared. Reset mid-run discards the run.
//  - States: IDLE -> (start & in_ready) CLEAR; (start & !in_ready) WAIT_IN -> (in_ready) CLEAR.
//  - CLEAR (1 cyc): mac_clr=1. -> COMPUTE.
//  - COMPUTE (PRECISION*N_IN cyc): rd_en=1; rd_bit outer 0..PRECISION-1, rd_addr_i inner 0..N_IN-1.
//    Last address -> DRAIN.
//  - DRAIN (MEM_LAT cyc): rd_en=0, delay line flushes final mac_en. -> EMIT.
//  - EMIT: out_valid=1; lane advances on out_valid&out_ready; out_neuron=g*P+out_lane.
//    Last lane of group = min(P, N_HIDDEN-g*P)-1 (partial final group: surplus lanes never shown).
//    Accepted last lane: more groups -> CLEAR with rd_addr_h+=P; else DONE.
//  - DONE (1 cyc): done=1, busy=1. -> IDLE.
//  - out_valid stays high, out_lane/out_neuron stable, while out_ready=0.
//  - start in any non-IDLE state ignored. abort wins over all transitions; delay line cleared.
//  - mac_en/mac_bit/mac_sign are a MEM_LAT-stage shift of (rd_en, rd_bit, sign); 0 when rd_en=0.
//  - Cycles per group with out_ready=1: 1 + PRECISION*N_IN + MEM_LAT + lanes_in_group.
// CONFIGURATION
//  SCHED_PERF_CNT_EN defined: perf_cycles clears on start accept, +1 every busy cycle incl. DONE,
//    saturates at 2^32-1, holds after done until next start.
//  Not defined: perf_cycles tied to 0, no counter logic.
// TESTING
//  1 Defaults, in_ready=1, out_ready=1, start pulse -> 16 groups, done at 32865 cycles after start edge;
//    out_neuron 0..63 in order; perf_cycles=32865 (with SCHED_PERF_CNT_EN).
//  2 N_HIDDEN=10,P=4 -> groups base 0,4,8; last group emits out_neuron 8,9 only; 10 results total.
//  3 out_ready low 3 cycles on neuron 5 -> out_valid held, out_neuron=5 stable, no skip/duplicate.
//  4 start with in_ready=0 for 20 cycles -> WAIT_IN, busy=1, rd_en=0; CLEAR 1 cycle after in_ready rises.
//  5 MEM_LAT=3 -> mac_en trails rd_en by 3 cycles; mac_sign only when mac_bit=15; DRAIN 3 cycles.
//  6 abort at cycle 500 of COMPUTE, then rst mid-EMIT on a rerun -> IDLE, all outputs 0, no done.

Source files
------------

// File: rtl/bitserial_layer_sched.sv
// Control sequencer for one bit-serial fully-connected layer: clear, bit-plane reads, drain, result emit per lane group.
// Optional run-cycle counter on perf_cycles when SCHED_PERF_CNT_EN is defined; otherwise perf_cycles is tied to 0.
module bitserial_layer_sched #(
  parameter int N_IN      = 128,
  parameter int N_HIDDEN  = 64,
  parameter int P         = 4,
  parameter int PRECISION = 16,
  parameter int MEM_LAT   = 1,
  localparam int HW = (N_HIDDEN  > 1) ? $clog2(N_HIDDEN)  : 1,
  localparam int IW = (N_IN      > 1) ? $clog2(N_IN)      : 1,
  localparam int BW = (PRECISION > 1) ? $clog2(PRECISION) : 1,
  localparam int LW = (P         > 1) ? $clog2(P)         : 1,
  localparam int DW = (MEM_LAT   > 1) ? $clog2(MEM_LAT)   : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [HW-1:0] rd_addr_h,
  output logic [IW-1:0] rd_addr_i,
  output logic [BW-1:0] rd_bit,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [BW-1:0] mac_bit,
  output logic          mac_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] out_lane,
  output logic [HW-1:0] out_neuron,
  output logic [31:0]   perf_cycles
);

  // state   | meaning
  // IDLE    | waiting for start
  // WAIT_IN | run accepted, waiting for a full input vector
  // CLEAR   | clear lane accumulators for the next group
  // COMPUTE | stream every (bit plane, input) read for the group
  // DRAIN   | let the last reads reach the lanes
  // EMIT    | present one lane result per handshake
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IN, S_CLEAR, S_COMPUTE, S_DRAIN, S_EMIT, S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          last_lane;
  logic          more_groups;

  // A partial final group stops at the last real neuron rather than at lane P-1.
  assign last_lane   = (int'(out_lane) == P - 1) || (int'(out_neuron) == N_HIDDEN - 1);
  assign more_groups = (int'(rd_addr_h) + P) < N_HIDDEN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      mac_clr    <= 1'b0;
      out_valid  <= 1'b0;
      rd_addr_h  <= '0;
      rd_addr_i  <= '0;
      rd_bit     <= '0;
      out_lane   <= '0;
      out_neuron <= '0;
      drain_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      mac_clr <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        rd_en      <= 1'b0;
        out_valid  <= 1'b0;
        rd_addr_h  <= '0;
        rd_addr_i  <= '0;
        rd_bit     <= '0;
        out_lane   <= '0;
        out_neuron <= '0;
        drain_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              busy      <= 1'b1;
              rd_addr_h <= '0;
              if (in_ready) begin
                state   <= S_CLEAR;
                mac_clr <= 1'b1;
              end else begin
                state <= S_WAIT_IN;
              end
            end
          end
          S_WAIT_IN: begin
            if (in_ready) begin
              state   <= S_CLEAR;
              mac_clr <= 1'b1;
            end
          end
          S_CLEAR: begin
            state     <= S_COMPUTE;
            rd_en     <= 1'b1;
            rd_addr_i <= '0;
            rd_bit    <= '0;
          end
          S_COMPUTE: begin
            if (rd_addr_i == IW'(N_IN - 1)) begin
              rd_addr_i <= '0;
              if (rd_bit == BW'(PRECISION - 1)) begin
                rd_bit    <= '0;
                rd_en     <= 1'b0;
                state     <= S_DRAIN;
                drain_cnt <= DW'(MEM_LAT - 1);
              end else begin
                rd_bit <= rd_bit + BW'(1);
              end
            end else begin
              rd_addr_i <= rd_addr_i + IW'(1);
            end
          end
          S_DRAIN: begin
            if (drain_cnt == '0) begin
              state      <= S_EMIT;
              out_valid  <= 1'b1;
              out_lane   <= '0;
              out_neuron <= rd_addr_h;
            end else begin
              drain_cnt <= drain_cnt - DW'(1);
            end
          end
          S_EMIT: begin
            if (out_ready) begin
              if (last_lane) begin
                out_valid  <= 1'b0;
                out_lane   <= '0;
                out_neuron <= '0;
                if (more_groups) begin
                  state     <= S_CLEAR;
                  mac_clr   <= 1'b1;
                  rd_addr_h <= rd_addr_h + HW'(P);
                end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end
              end else begin
                out_lane   <= out_lane + LW'(1);
                out_neuron <= out_neuron + HW'(1);
              end
            end
          end
          S_DONE: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            rd_addr_h <= '0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read-to-lane alignment: the lanes see each read's bit plane MEM_LAT cycles later.
  logic [MEM_LAT-1:0] en_dly;
  logic [MEM_LAT-1:0] sign_dly;
  logic [BW-1:0]      bit_dly [MEM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_dly   <= '0;
      sign_dly <= '0;
      for (int k = 0; k < MEM_LAT; k++) bit_dly[k] <= '0;
    end else if (abort) begin
      en_dly   <= '0;
      sign_dly <= '0;
      for (int k = 0; k < MEM_LAT; k++) bit_dly[k] <= '0;
    end else begin
      en_dly[0]   <= rd_en;
      sign_dly[0] <= rd_en && (rd_bit == BW'(PRECISION - 1));
      bit_dly[0]  <= rd_en ? rd_bit : '0;
      for (int k = 1; k < MEM_LAT; k++) begin
        en_dly[k]   <= en_dly[k-1];
        sign_dly[k] <= sign_dly[k-1];
        bit_dly[k]  <= bit_dly[k-1];
      end
    end
  end

  assign mac_en   = en_dly[MEM_LAT-1];
  assign mac_sign = sign_dly[MEM_LAT-1];
  assign mac_bit  = bit_dly[MEM_LAT-1];

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if ((state == S_IDLE) && start && !abort) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule
